mux_arb_reg: RTL
================

Name: mux_arb_reg

Overview:
- Parametrised N-channel successor to the core's 2:1 and 3:1 datapath selectors.
- Selects one of NCH valid/ready input channels by round-robin or fixed priority and registers the winner into a single output stage with valid/ready handshake.
- Intended for merging request streams, e.g. I-fetch / D-access / debug into one memory port, or writeback source merging.

Parameters:
- WIDTH, 32: data width per channel.
- NCH, 4: number of input channels (2..16).
- SELW, $clog2(NCH): width of the grant index.
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority (channel 0 highest).

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  NCH  per-channel request valid.
- in_ready  out  NCH  per-channel accept. One-hot or zero.
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  out  1  output register holds data.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  WIDTH  registered selected data.
- out_sel  out  SELW  index of the channel whose data is in out_data.

Behaviour:
- Reset (async, rstn=0):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer rr_ptr=0.
  - in_ready is combinational and therefore 0 while out_valid=0 and no in_valid is set.
- Register free condition: free = !out_valid | out_ready.
- Grant (combinational, only when free=1):
  - ARB_MODE=1: lowest index i with in_valid[i]=1.
  - ARB_MODE=0: first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NCH (wrap from NCH-1 to 0).
  - in_ready[g]=1 only for the granted g. All other bits are 0. All bits are 0 when free=0.
- Transfer (handshake in_valid[g] & in_ready[g]) at a clock edge:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - Round-robin mode: rr_ptr <= (g==NCH-1) ? 0 : g+1.
- Drain without refill (out_valid & out_ready, no in_valid): out_valid <= 0. out_data and out_sel hold their last value.
- Simultaneous drain and refill: both happen in the same cycle. Throughput is 1 transfer/cycle with no bubble.
- Backpressure (out_valid=1, out_ready=0):
  - out_data, out_sel and out_valid are held.
  - All in_ready are 0.
  - rr_ptr is unchanged.
- Latency: in_valid to out_valid is 1 cycle when free.
- Ready usage: in_ready depends on in_valid and out_ready combinationally. Upstream must not make in_valid depend on in_ready.
- rr_ptr advances only on a transfer. Idle cycles never move it.
- Fixed-priority mode: rr_ptr is unused and stays at 0.
- Reset asserted mid-transfer: output is cleared immediately (asynchronous). The first grant after release uses rr_ptr=0.
- No combinational path from in_data to out_data.

Decomposition:
- Add to shared defines (xgriscv_defines.v):
  - `ARB_RR (0) and `ARB_FIXED (1) mode constants.
  - `MUXARB_W default width 32.
- One sub-module: rr_grant (NCH, SELW, ARB_MODE).
  - Purely combinational.
  - Inputs: req[NCH], ptr[SELW].
  - Outputs: gnt_vld, gnt_idx[SELW].
  - Implemented as a double-width masked priority encode.
- mux_arb_reg holds the output register, rr_ptr and handshake logic.

Test Plan:
1. Reset with all in_valid=1, then release rstn: cycle 1 grants ch0 and out_data=in_data[0]. With out_ready=1 held, grants follow 1,2,3,0,1 with no bubble.
2. Fixed mode (ARB_MODE=1), in_valid=4'b1010, out_ready=1: every cycle grants ch1 and ch3 never receives in_ready (starvation is expected).
3. Backpressure: fill output with ch2 data 32'hDEAD_BEEF, hold out_ready=0 for 5 cycles while in_valid=4'b1111. out_data stays DEAD_BEEF, out_sel=2, in_ready=0, rr_ptr=3. On out_ready=1, ch3 is granted in the same cycle.
4. Wrap: rr_ptr=3 and only ch0 valid -> ch0 granted and rr_ptr becomes 1. With only ch3 valid and rr_ptr=0, ch3 is granted and rr_ptr wraps to 0.
5. Drain without refill: out_valid=1, out_ready=1, in_valid=0 -> next cycle out_valid=0 and out_data keeps its last value.
6. Assert rstn=0 asynchronously mid-stream, between clock edges: out_valid drops to 0 immediately. After release, the grant restarts from ch0. Also run NCH=3 and WIDTH=8 to check the non-power-of-2 wrap (2 -> 0).

Source files
------------

// File: rtl/mux_arb_reg_pkg.sv
// rtl/mux_arb_reg_pkg.sv - shared constants for the arbitrated output-register mux
//
// Purpose: arbitration mode selectors and default datapath sizing, imported by
// the interface, the grant encoder and the top.
package mux_arb_reg_pkg;

    localparam int ARB_RR     = 0;   // round-robin, pointer follows the last winner
    localparam int ARB_FIXED  = 1;   // fixed priority, channel 0 highest
    localparam int MUXARB_W   = 32;  // default per-channel data width
    localparam int MUXARB_NCH = 4;   // default channel count

endpackage

// File: rtl/mux_arb_reg_if.sv
// rtl/mux_arb_reg_if.sv - N-channel request bundle plus single output stage
//
// Purpose: groups the per-channel valid/ready/data inputs and the registered
// output handshake of mux_arb_reg.
// Modports:
//   master - upstream/downstream environment (drives in_valid, in_data, out_ready)
//   slave  - the arbiter (drives in_ready, out_valid, out_data, out_sel)
interface mux_arb_reg_if
    import mux_arb_reg_pkg::*;
#(
    parameter int WIDTH = MUXARB_W,
    parameter int NCH   = MUXARB_NCH,
    parameter int SELW  = $clog2(NCH)
);

    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [NCH*WIDTH-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_sel;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/mux_arb_reg_rr_grant.sv
// rtl/mux_arb_reg_rr_grant.sv - combinational round-robin / fixed-priority grant encoder
//
// Purpose: picks one requester out of NCH.
// Ports:
//   req     in  NCH   request vector
//   ptr     in  SELW  round-robin start index (ignored in fixed mode)
//   gnt_vld out 1     any request present
//   gnt_idx out SELW  winning index (0 when no request)
module rr_grant
    import mux_arb_reg_pkg::*;
#(
    parameter int NCH      = MUXARB_NCH,
    parameter int SELW     = $clog2(NCH),
    parameter int ARB_MODE = ARB_RR
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_vld,
    output logic [SELW-1:0] gnt_idx
);

    // Double-width vector: the lower copy has requests below ptr masked off,
    // the upper copy is untouched. The lowest set bit of the whole vector is
    // the first requester at or after ptr, wrapping through the upper copy.
    logic [2*NCH-1:0] masked;

    always_comb begin
        masked = {req, req};
        if (ARB_MODE == ARB_RR) begin
            for (int i = 0; i < NCH; i++) begin
                if (i < int'(ptr)) begin
                    masked[i] = 1'b0;
                end
            end
        end else begin
            // Fixed priority: only the unmasked lower copy takes part.
            masked[2*NCH-1:NCH] = '0;
        end

        gnt_idx = '0;
        for (int i = 2*NCH-1; i >= 0; i--) begin
            if (masked[i]) begin
                gnt_idx = SELW'(i % NCH);
            end
        end

        gnt_vld = |req;
    end

endmodule

// File: rtl/mux_arb_reg.sv
// rtl/mux_arb_reg.sv - N:1 arbitrated selector with a registered valid/ready output stage
//
// Purpose: grants one of NCH input channels (round-robin or fixed priority)
// and loads its data into a single output register.
// Ports:
//   clk   in  rising-edge clock
//   rstn  in  asynchronous active-low reset
//   bus   slave modport of mux_arb_reg_if (in_valid/in_ready/in_data,
//         out_valid/out_ready/out_data/out_sel)
module mux_arb_reg
    import mux_arb_reg_pkg::*;
#(
    parameter int WIDTH    = MUXARB_W,
    parameter int NCH      = MUXARB_NCH,
    parameter int SELW     = $clog2(NCH),
    parameter int ARB_MODE = ARB_RR
) (
    input  logic          clk,
    input  logic          rstn,
    mux_arb_reg_if.slave  bus
);

    logic [SELW-1:0]  rr_ptr;
    logic             gnt_vld;
    logic [SELW-1:0]  gnt_idx;
    logic             free;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    // The register can take new data when empty or being drained this cycle,
    // which gives back-to-back transfers without a bubble.
    assign free = !bus.out_valid || bus.out_ready;
    assign xfer = free && gnt_vld;

    rr_grant #(
        .NCH      (NCH),
        .SELW     (SELW),
        .ARB_MODE (ARB_MODE)
    ) u_grant (
        .req     (bus.in_valid),
        .ptr     (rr_ptr),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        bus.in_ready = '0;
        if (xfer) begin
            bus.in_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt_idx == SELW'(i)) begin
                sel_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
            rr_ptr        <= '0;
        end else begin
            if (xfer) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= sel_data;
                bus.out_sel   <= gnt_idx;
                // Pointer moves past the winner; stays at 0 in fixed mode.
                if (ARB_MODE == ARB_RR) begin
                    rr_ptr <= (gnt_idx == SELW'(NCH-1)) ? '0 : gnt_idx + SELW'(1);
                end
            end else if (bus.out_ready) begin
                // Drain with no refill: data and index keep their last value.
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule
